// File: rtl/ysyx_23060208_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060208_bus_pkg
//  Brief    : AXI4-Lite response codes, crossbar state encoding, default map
//  Revision : 1.0
// ============================================================================
package ysyx_23060208_bus_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int         ST_W      = 3;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_WR     = 3'd2;
    localparam logic [2:0] ST_ERR_R  = 3'd3;
    localparam logic [2:0] ST_ERR_B  = 3'd4;

    localparam logic [31:0] CLINT_BASE  = 32'ha000_0048;
    localparam logic [31:0] CLINT_MASK  = 32'hffff_fff8;
    localparam logic [31:0] SERIAL_BASE = 32'ha000_03f8;
    localparam logic [31:0] SERIAL_MASK = 32'hffff_ffff;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060208_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060208_rr_arb
//  Brief    : Combinational round-robin pick of the first requester at/after ptr
//  Revision : 1.0
// ============================================================================
module ysyx_23060208_rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int w_j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(ptr) + k) % N;
            if (!any && req[w_j]) begin
                gnt[w_j] = 1'b1;
                gnt_idx  = IW'(w_j);
                any      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060208_axil_xbar.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060208_axil_xbar
//  Brief    : N_MST x N_SLV AXI4-Lite crossbar, round-robin, one transaction
//             in flight, base/mask decode with local DECERR for unmapped hits
//  Revision : 1.0
// ============================================================================
module ysyx_23060208_axil_xbar
    import ysyx_23060208_bus_pkg::*;
#(
    parameter int N_MST = 2,
    parameter int N_SLV = 3,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {32'h0, SERIAL_BASE, CLINT_BASE},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {32'h0, SERIAL_MASK, CLINT_MASK},
    localparam int SW = DW / 8,
    localparam int MW = (N_MST > 1) ? $clog2(N_MST) : 1,
    localparam int XW = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MST*AW-1:0] m_araddr,
    input  logic [N_MST-1:0]    m_arvalid,
    output logic [N_MST-1:0]    m_arready,
    output logic [N_MST*DW-1:0] m_rdata,
    output logic [N_MST*2-1:0]  m_rresp,
    output logic [N_MST-1:0]    m_rvalid,
    input  logic [N_MST-1:0]    m_rready,
    input  logic [N_MST*AW-1:0] m_awaddr,
    input  logic [N_MST-1:0]    m_awvalid,
    output logic [N_MST-1:0]    m_awready,
    input  logic [N_MST*DW-1:0] m_wdata,
    input  logic [N_MST*SW-1:0] m_wstrb,
    input  logic [N_MST-1:0]    m_wvalid,
    output logic [N_MST-1:0]    m_wready,
    output logic [N_MST*2-1:0]  m_bresp,
    output logic [N_MST-1:0]    m_bvalid,
    input  logic [N_MST-1:0]    m_bready,
    output logic [N_SLV*AW-1:0] s_araddr,
    output logic [N_SLV-1:0]    s_arvalid,
    input  logic [N_SLV-1:0]    s_arready,
    input  logic [N_SLV*DW-1:0] s_rdata,
    input  logic [N_SLV*2-1:0]  s_rresp,
    input  logic [N_SLV-1:0]    s_rvalid,
    output logic [N_SLV-1:0]    s_rready,
    output logic [N_SLV*AW-1:0] s_awaddr,
    output logic [N_SLV-1:0]    s_awvalid,
    input  logic [N_SLV-1:0]    s_awready,
    output logic [N_SLV*DW-1:0] s_wdata,
    output logic [N_SLV*SW-1:0] s_wstrb,
    output logic [N_SLV-1:0]    s_wvalid,
    input  logic [N_SLV-1:0]    s_wready,
    input  logic [N_SLV*2-1:0]  s_bresp,
    input  logic [N_SLV-1:0]    s_bvalid,
    output logic [N_SLV-1:0]    s_bready,
    output logic                busy,
    output logic [MW-1:0]       gnt_mst
);

    logic [ST_W-1:0]  r_state, w_state_nxt;
    logic [MW-1:0]    r_gnt, r_ptr;
    logic [XW-1:0]    r_slv;
    logic             r_ar_done, r_aw_done, r_w_done;

    logic [N_MST-1:0] w_req, w_arb_gnt;
    logic [MW-1:0]    w_arb_idx;
    logic             w_arb_any, w_dir_rd;
    logic [AW-1:0]    w_dec_addr;
    logic [N_SLV-1:0] w_hit;
    logic [XW-1:0]    w_hit_idx;
    logic             w_hit_any;
    logic             w_ar_hs, w_aw_hs, w_w_hs, w_done, w_bok;
    int               w_g, w_s;

    assign w_req = m_arvalid | m_awvalid;

    ysyx_23060208_rr_arb #(.N(N_MST), .IW(MW)) u_arb (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx),
        .any     (w_arb_any)
    );

    // A master presenting both AR and AW is served as a read first.
    assign w_dir_rd   = |(w_arb_gnt & m_arvalid);
    assign w_dec_addr = w_dir_rd ? m_araddr[int'(w_arb_idx)*AW +: AW]
                                 : m_awaddr[int'(w_arb_idx)*AW +: AW];

    generate
        for (genvar gs = 0; gs < N_SLV; gs++) begin : g_dec
            assign w_hit[gs] = (w_dec_addr & SLV_MASK[gs*AW +: AW]) == SLV_BASE[gs*AW +: AW];
        end
    endgenerate

    // Overlapping windows resolve to the lowest slave index.
    always_comb begin
        w_hit_idx = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if (w_hit[k]) w_hit_idx = XW'(k);
        end
    end
    assign w_hit_any = |w_hit;

    assign busy    = (r_state != ST_IDLE);
    assign gnt_mst = busy ? r_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_slv     <= '0;
            r_ptr     <= '0;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (w_arb_any) begin
                r_gnt <= w_arb_idx;
                r_slv <= w_hit_idx;
            end
        end else begin
            if (w_ar_hs) r_ar_done <= 1'b1;
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_done)  r_ptr <= (r_gnt == MW'(N_MST - 1)) ? '0 : r_gnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g         = int'(r_gnt);
        w_s         = int'(r_slv);
        w_bok       = r_aw_done & r_w_done;
        w_ar_hs     = 1'b0;
        w_aw_hs     = 1'b0;
        w_w_hs      = 1'b0;
        w_done      = 1'b0;
        m_arready = '0; m_rdata  = '0; m_rresp   = '0; m_rvalid = '0;
        m_awready = '0; m_wready = '0; m_bresp   = '0; m_bvalid = '0;
        s_araddr  = '0; s_arvalid = '0; s_rready = '0;
        s_awaddr  = '0; s_awvalid = '0; s_wdata  = '0; s_wstrb = '0;
        s_wvalid  = '0; s_bready  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    if (w_dir_rd) w_state_nxt = w_hit_any ? ST_RD : ST_ERR_R;
                    else          w_state_nxt = w_hit_any ? ST_WR : ST_ERR_B;
                end
            end
            ST_RD: begin
                s_araddr[w_s*AW +: AW] = m_araddr[w_g*AW +: AW];
                s_arvalid[w_s]         = m_arvalid[w_g] & ~r_ar_done;
                m_arready[w_g]         = s_arready[w_s] & ~r_ar_done;
                w_ar_hs                = m_arvalid[w_g] & s_arready[w_s] & ~r_ar_done;
                m_rdata[w_g*DW +: DW]  = s_rdata[w_s*DW +: DW];
                m_rresp[w_g*2 +: 2]    = s_rresp[w_s*2 +: 2];
                m_rvalid[w_g]          = s_rvalid[w_s];
                s_rready[w_s]          = m_rready[w_g];
                w_done                 = s_rvalid[w_s] & m_rready[w_g];
            end
            ST_WR: begin
                s_awaddr[w_s*AW +: AW] = m_awaddr[w_g*AW +: AW];
                s_awvalid[w_s]         = m_awvalid[w_g] & ~r_aw_done;
                m_awready[w_g]         = s_awready[w_s] & ~r_aw_done;
                w_aw_hs                = m_awvalid[w_g] & s_awready[w_s] & ~r_aw_done;
                s_wdata[w_s*DW +: DW]  = m_wdata[w_g*DW +: DW];
                s_wstrb[w_s*SW +: SW]  = m_wstrb[w_g*SW +: SW];
                s_wvalid[w_s]          = m_wvalid[w_g] & ~r_w_done;
                m_wready[w_g]          = s_wready[w_s] & ~r_w_done;
                w_w_hs                 = m_wvalid[w_g] & s_wready[w_s] & ~r_w_done;
                // A B response is only meaningful once both AW and W have landed.
                m_bresp[w_g*2 +: 2]    = s_bresp[w_s*2 +: 2];
                m_bvalid[w_g]          = s_bvalid[w_s] & w_bok;
                s_bready[w_s]          = m_bready[w_g] & w_bok;
                w_done                 = s_bvalid[w_s] & m_bready[w_g] & w_bok;
            end
            ST_ERR_R: begin
                m_arready[w_g] = ~r_ar_done;
                w_ar_hs        = m_arvalid[w_g] & ~r_ar_done;
                m_rvalid[w_g]  = r_ar_done;
                if (r_ar_done) m_rresp[w_g*2 +: 2] = RESP_DECERR;
                w_done         = r_ar_done & m_rready[w_g];
            end
            ST_ERR_B: begin
                m_awready[w_g] = ~r_aw_done;
                w_aw_hs        = m_awvalid[w_g] & ~r_aw_done;
                m_wready[w_g]  = ~r_w_done;
                w_w_hs         = m_wvalid[w_g] & ~r_w_done;
                m_bvalid[w_g]  = w_bok;
                if (w_bok) m_bresp[w_g*2 +: 2] = RESP_DECERR;
                w_done         = w_bok & m_bready[w_g];
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_done) w_state_nxt = ST_IDLE;
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060208_axil_xbar.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060208_axil_xbar
//  Brief    : Directed self-checking bench for the AXI4-Lite crossbar
//  Revision : 1.0
// ============================================================================
module tb_ysyx_23060208_axil_xbar;

    // Slave 2 is moved to a 2 GiB window so that low addresses are unmapped.
    localparam logic [95:0] C_BASE = {32'h8000_0000, 32'ha000_03f8, 32'ha000_0048};
    localparam logic [95:0] C_MASK = {32'h8000_0000, 32'hffff_ffff, 32'hffff_fff8};

    logic        clk, rst;
    logic [63:0] m_araddr;  logic [1:0] m_arvalid, m_arready;
    logic [63:0] m_rdata;   logic [3:0] m_rresp;   logic [1:0] m_rvalid, m_rready;
    logic [63:0] m_awaddr;  logic [1:0] m_awvalid, m_awready;
    logic [63:0] m_wdata;   logic [7:0] m_wstrb;   logic [1:0] m_wvalid, m_wready;
    logic [3:0]  m_bresp;   logic [1:0] m_bvalid, m_bready;
    logic [95:0] s_araddr;  logic [2:0] s_arvalid, s_arready;
    logic [95:0] s_rdata;   logic [5:0] s_rresp;   logic [2:0] s_rvalid, s_rready;
    logic [95:0] s_awaddr;  logic [2:0] s_awvalid, s_awready;
    logic [95:0] s_wdata;   logic [11:0] s_wstrb;  logic [2:0] s_wvalid, s_wready;
    logic [5:0]  s_bresp;   logic [2:0] s_bvalid, s_bready;
    logic        busy;
    logic [0:0]  gnt_mst;
    logic        w_any_out;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          mst;
        logic [31:0] addr;
        int          slv;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } rd_vec_t;

    rd_vec_t vecs [5];
    int      exp_g [3];

    ysyx_23060208_axil_xbar #(
        .N_MST(2), .N_SLV(3), .AW(32), .DW(32),
        .SLV_BASE(C_BASE), .SLV_MASK(C_MASK)
    ) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .busy(busy), .gnt_mst(gnt_mst)
    );

    assign w_any_out = |{m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready,
                         m_bresp, m_bvalid, s_araddr, s_arvalid, s_rready, s_awaddr,
                         s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready, busy, gnt_mst};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_read(input int m, input logic [31:0] a, input int slv,
                           input logic [31:0] d, input logic [1:0] r);
        logic [2:0] exp_ar;
        exp_ar = (slv >= 0) ? (3'b001 << slv) : 3'b000;
        @(negedge clk);
        m_araddr[m*32 +: 32] = a;
        m_arvalid[m] = 1'b1;
        @(negedge clk);
        chk("rd_busy", busy, 1);
        chk("rd_gnt", gnt_mst, m);
        chk("rd_s_arvalid", s_arvalid, exp_ar);
        chk("rd_m_arready", m_arready, 2'b01 << m);
        if (slv >= 0) chk("rd_s_araddr", s_araddr[slv*32 +: 32], a);
        @(negedge clk);
        m_arvalid[m] = 1'b0;
        chk("rd_ar_masked", s_arvalid, 0);
        if (slv >= 0) s_rvalid[slv] = 1'b1;
        #1;
        chk("rd_rvalid", m_rvalid, 2'b01 << m);
        chk("rd_rdata", m_rdata[m*32 +: 32], d);
        chk("rd_rresp", m_rresp[m*2 +: 2], r);
        @(negedge clk);
        s_rvalid = '0;
        chk("rd_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{0, 32'h8000_0000,  2, 32'h0000_0413, 2'b00};
        vecs[1] = '{1, 32'ha000_004c,  0, 32'hc0ff_ee00, 2'b10};
        vecs[2] = '{1, 32'h1000_0000, -1, 32'h0000_0000, 2'b11};
        vecs[3] = '{0, 32'ha000_03f8,  1, 32'h0000_0055, 2'b00};
        vecs[4] = '{1, 32'hffff_fff0,  2, 32'h0000_0413, 2'b00};
        exp_g   = '{0, 1, 0};

        rst = 1'b1;
        m_araddr = '0; m_arvalid = '0; m_rready = 2'b11;
        m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
        m_bready = 2'b11;
        s_arready = 3'b111; s_awready = 3'b111; s_wready = 3'b111;
        s_rdata = {32'h0000_0413, 32'h0000_0055, 32'hc0ff_ee00};
        s_rresp = {2'b00, 2'b00, 2'b10};
        s_rvalid = '0; s_bresp = '0; s_bvalid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_outputs", w_any_out, 0);

        for (int i = 0; i < 5; i++) begin
            do_read(vecs[i].mst, vecs[i].addr, vecs[i].slv, vecs[i].rdata, vecs[i].rresp);
        end

        // m1 write to UART, W raised two cycles ahead of AW; AW stalled one cycle.
        @(negedge clk);
        m_wdata[63:32] = 32'h41; m_wstrb[7:4] = 4'h1; m_wvalid[1] = 1'b1;
        @(negedge clk);
        chk("wr_w_only_idle", busy, 0);
        chk("wr_w_only_s", s_wvalid, 0);
        @(negedge clk);
        m_awaddr[63:32] = 32'ha000_03f8; m_awvalid[1] = 1'b1; s_awready = 3'b000;
        @(negedge clk);
        chk("wr_gnt", gnt_mst, 1);
        chk("wr_s_awvalid", s_awvalid, 3'b010);
        chk("wr_s_wvalid", s_wvalid, 3'b010);
        chk("wr_s_awaddr", s_awaddr[63:32], 32'ha000_03f8);
        chk("wr_s_wdata", s_wdata[63:32], 32'h41);
        chk("wr_s_wstrb", s_wstrb[7:4], 4'h1);
        chk("wr_m_awready", m_awready, 0);
        @(negedge clk);
        m_wvalid[1] = 1'b0;
        chk("wr_w_masked", s_wvalid, 0);
        chk("wr_aw_pending", s_awvalid, 3'b010);
        s_bvalid[1] = 1'b1;
        #1;
        chk("wr_b_gated", m_bvalid, 0);
        chk("wr_bready_gated", s_bready, 0);
        s_awready = 3'b111;
        @(negedge clk);
        m_awvalid[1] = 1'b0;
        chk("wr_aw_masked", s_awvalid, 0);
        chk("wr_bvalid", m_bvalid, 2'b10);
        chk("wr_bresp", m_bresp[3:2], 2'b00);
        chk("wr_s_bready", s_bready, 3'b010);
        @(negedge clk);
        s_bvalid = '0;
        chk("wr_idle", busy, 0);

        // m1 write to an unmapped address.
        @(negedge clk);
        m_awaddr[63:32] = 32'h1000_0000; m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1;
        @(negedge clk);
        chk("werr_busy", busy, 1);
        chk("werr_s_awvalid", s_awvalid, 0);
        chk("werr_s_wvalid", s_wvalid, 0);
        chk("werr_awready", m_awready, 2'b10);
        chk("werr_wready", m_wready, 2'b10);
        chk("werr_no_b_yet", m_bvalid, 0);
        @(negedge clk);
        m_awvalid = '0; m_wvalid = '0;
        chk("werr_bvalid", m_bvalid, 2'b10);
        chk("werr_bresp", m_bresp[3:2], 2'b11);
        @(negedge clk);
        chk("werr_idle", busy, 0);

        // Both masters read continuously; grants must alternate.
        m_araddr = {32'h8000_0000, 32'h8000_0000};
        @(negedge clk);
        m_arvalid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arb_gnt", gnt_mst, exp_g[k]);
            chk("arb_s_arvalid", s_arvalid, 3'b100);
            @(negedge clk);
            m_arvalid[exp_g[k]] = 1'b0;
            s_rvalid[2] = 1'b1;
            #1;
            chk("arb_rvalid", m_rvalid, 2'b01 << exp_g[k]);
            @(negedge clk);
            s_rvalid = '0;
            chk("arb_idle", busy, 0);
            if (k < 2) m_arvalid[exp_g[k]] = 1'b1;
            else       m_arvalid = '0;
        end

        // Reset while an R beat is pending on m0.
        m_rready[0] = 1'b0;
        @(negedge clk);
        m_araddr[31:0] = 32'h8000_0000; m_arvalid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_arvalid[0] = 1'b0;
        s_rvalid[2] = 1'b1;
        #1;
        chk("rst_rvalid_pending", m_rvalid, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_outputs", w_any_out, 0);
        rst = 1'b0; s_rvalid = '0; m_rready = 2'b11;
        do_read(0, 32'h8000_0000, 2, 32'h0000_0413, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
